mole_round_judge: RTL and testbench

- Downstream of the mole display stage and its countdown: consumes each new mole (`mole_valid` pulse plus the chosen HEX position) and the player's key and position switches.
- Opens a reaction window per mole and judges each round as hit, miss or timeout.
- Keeps score and a miss count, and shrinks the window on every hit.
- Feeds the next window length back to the display countdown through a parallel-load pulse and data.

---
 rtl/mole_round_judge.sv | 141 ++++++++++++++
 tb/tb_mole_round_judge.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mole_round_judge.sv
// Round judge for the whack-a-mole game: opens a reaction window for each mole,
// scores each press as a hit or a miss, and passes the next window length to the countdown.
module mole_round_judge #(
  parameter int WIN_W       = 27,
  parameter int INIT_WINDOW = 50_000_000,
  parameter int STEP        = 2_500_000,
  parameter int MIN_WINDOW  = 12_500_000,
  parameter int MAX_MISSES  = 3,
  parameter int SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               mole_valid,
  input  logic [1:0]         mole_pos,
  input  logic [1:0]         guess_pos,
  input  logic               whack_n,
  output logic               active,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         misses,
  output logic               round_load,
  output logic [WIN_W-1:0]   load_value,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [WIN_W-1:0]   timer
);

  // state     | meaning
  // S_IDLE    | powered up, waiting for start
  // S_ARM     | countdown running, waiting for the next mole
  // S_WAIT    | reaction window open, timer counting down
  // S_HIT     | one cycle after a correct press
  // S_MISS    | one cycle after a wrong press or timeout
  // S_OVER    | miss limit reached, score frozen
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HIT  = 3'd3;
  localparam logic [2:0] S_MISS = 3'd4;
  localparam logic [2:0] S_OVER = 3'd5;

  localparam logic [WIN_W-1:0]   INIT_V = WIN_W'(INIT_WINDOW);
  localparam logic [WIN_W-1:0]   STEP_V = WIN_W'(STEP);
  localparam logic [WIN_W-1:0]   MIN_V  = WIN_W'(MIN_WINDOW);
  localparam logic [WIN_W-1:0]   ONE_W  = WIN_W'(1);
  localparam logic [1:0]         MAX_M  = 2'(MAX_MISSES);
  localparam logic [SCORE_W-1:0] ONE_S  = SCORE_W'(1);

  logic [2:0]       state;
  logic [1:0]       pos_q;
  logic             sync1, sync2, sync2_d, press;
  logic [WIN_W:0]   dec_wide;
  logic [WIN_W-1:0] next_load;
  logic [1:0]       misses_inc;

  // Two-flop synchronizer, then a registered falling-edge detect: one press per key-down.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      sync2_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      sync1   <= whack_n;
      sync2   <= sync1;
      sync2_d <= sync2;
      press   <= sync2_d & ~sync2;
    end
  end

  // The extra MSB catches a borrow when the window is already below STEP.
  assign dec_wide   = {1'b0, load_value} - {1'b0, STEP_V};
  assign next_load  = (dec_wide[WIN_W] || (dec_wide[WIN_W-1:0] < MIN_V)) ? MIN_V
                                                                         : dec_wide[WIN_W-1:0];
  assign misses_inc = misses + 2'd1;

  assign active    = (state != S_IDLE) && (state != S_OVER);
  assign game_over = (state == S_OVER);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      pos_q      <= 2'd0;
      score      <= '0;
      misses     <= 2'd0;
      load_value <= INIT_V;
      timer      <= '0;
      round_load <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      round_load <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (start) begin
        score      <= '0;
        misses     <= 2'd0;
        load_value <= INIT_V;
        timer      <= '0;
        round_load <= 1'b1;
        state      <= S_ARM;
      end else begin
        case (state)
          S_IDLE: ;
          S_ARM: begin
            if (mole_valid) begin
              pos_q <= mole_pos;
              timer <= load_value - ONE_W;
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (press && (guess_pos == pos_q)) begin
              timer      <= '0;
              score      <= (score == '1) ? score : score + ONE_S;
              load_value <= next_load;
              hit_pulse  <= 1'b1;
              round_load <= 1'b1;
              state      <= S_HIT;
            end else if (press || (timer == '0)) begin
              // A press landing on the last cycle is judged, never counted as a timeout.
              timer      <= '0;
              misses     <= misses_inc;
              miss_pulse <= 1'b1;
              round_load <= (misses_inc != MAX_M);
              state      <= S_MISS;
            end else begin
              timer <= timer - ONE_W;
            end
          end
          S_HIT:   state <= S_ARM;
          S_MISS:  state <= (misses == MAX_M) ? S_OVER : S_ARM;
          S_OVER:  ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mole_round_judge.sv
// Randomised and directed rounds against a round-level model of the judge.
module tb_mole_round_judge;
  localparam int WIN_W = 27;
  localparam int SCORE_W = 8;
  localparam int INIT = 20, STEP = 5, MINW = 8, MAXM = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0, mole_valid = 1'b0, whack_n = 1'b1;
  logic [1:0] mole_pos = 2'd0, guess_pos = 2'd0;
  logic active, game_over, round_load, hit_pulse, miss_pulse;
  logic [SCORE_W-1:0] score;
  logic [1:0] misses;
  logic [WIN_W-1:0] load_value, timer;

  int n_cmp = 0, n_bad = 0;
  int m_score, m_misses, m_load;
  bit m_over;

  mole_round_judge #(
    .WIN_W(WIN_W), .INIT_WINDOW(INIT), .STEP(STEP), .MIN_WINDOW(MINW),
    .MAX_MISSES(MAXM), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mole_valid(mole_valid),
    .mole_pos(mole_pos), .guess_pos(guess_pos), .whack_n(whack_n),
    .active(active), .game_over(game_over), .score(score), .misses(misses),
    .round_load(round_load), .load_value(load_value), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .timer(timer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_score"}, int'(score), m_score);
    chk({tag, "_misses"}, int'(misses), m_misses);
    chk({tag, "_load"}, int'(load_value), m_load);
    chk({tag, "_timer"}, int'(timer), 0);
    chk({tag, "_hit"}, int'(hit_pulse), 0);
    chk({tag, "_miss"}, int'(miss_pulse), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_score = 0; m_misses = 0; m_load = INIT; m_over = 0;
    chk("start_rl", int'(round_load), 1);
    chk("start_active", int'(active), 1);
    chk_idle_outputs("start");
  endtask

  // One round: mole at p, press (if any) first sampled k cycles after mole_valid,
  // key held at least 'hold' cycles past the judgement.
  task automatic run_round(input int p, input bit match, input bit do_press,
                           input int k, input int hold);
    int w, exp_edge, post;
    bit hit, judged;
    w = m_load;
    judged = do_press && (k + 3 <= w);
    exp_edge = judged ? k + 3 : w;
    hit = judged && match;
    mole_pos = 2'(p);
    guess_pos = match ? 2'(p) : 2'(p) ^ 2'($urandom_range(1, 3));
    mole_valid = 1'b1;
    tick();
    mole_valid = 1'b0;
    chk("win_timer0", int'(timer), w - 1);
    for (int j = 1; j <= exp_edge; j++) begin
      if (do_press && j == k) whack_n = 1'b0;
      tick();
      if (j < exp_edge) begin
        chk("win_timer", int'(timer), w - 1 - j);
        chk("win_nohit", int'(hit_pulse | miss_pulse | round_load), 0);
      end
    end
    if (hit) begin
      m_score = (m_score < 255) ? m_score + 1 : 255;
      m_load = (m_load - STEP < MINW) ? MINW : m_load - STEP;
    end else begin
      m_misses++;
      if (m_misses == MAXM) m_over = 1;
    end
    chk("judge_hit", int'(hit_pulse), int'(hit));
    chk("judge_miss", int'(miss_pulse), int'(!hit));
    chk("judge_rl", int'(round_load), int'(!m_over));
    chk("judge_score", int'(score), m_score);
    chk("judge_misses", int'(misses), m_misses);
    chk("judge_load", int'(load_value), m_load);
    chk("judge_timer", int'(timer), 0);
    post = (hold > 6) ? hold : 6;
    for (int j = exp_edge + 1; j <= exp_edge + post; j++) begin
      if (do_press && j == k) whack_n = 1'b0;
      tick();
      chk("post_quiet", int'(hit_pulse | miss_pulse | round_load), 0);
    end
    whack_n = 1'b1;
    repeat (4) tick();
    chk("post_over", int'(game_over), int'(m_over));
    chk("post_active", int'(active), int'(!m_over));
    chk_idle_outputs("post");
  endtask

  initial begin
    m_score = 0; m_misses = 0; m_load = INIT; m_over = 0;
    #12;
    chk("rst_active", int'(active), 0);
    chk("rst_over", int'(game_over), 0);
    chk("rst_rl", int'(round_load), 0);
    chk_idle_outputs("rst");
    reset_n = 1'b1;
    tick();

    // Reset mid-window
    do_start();
    mole_pos = 2'd1;
    mole_valid = 1'b1;
    tick();
    mole_valid = 1'b0;
    repeat (9) tick();
    chk("midwait_timer", int'(timer), 10);
    #2 reset_n = 1'b0;
    #1;
    m_score = 0; m_misses = 0; m_load = INIT;
    chk("midrst_active", int'(active), 0);
    chk("midrst_rl", int'(round_load), 0);
    chk_idle_outputs("midrst");
    tick();
    reset_n = 1'b1;
    tick();
    chk("midrst_idle", int'(active), 0);

    // Hits down to the floor, the last one landing exactly on timer==0
    do_start();
    run_round(2, 1, 1, 5, 0);
    run_round(0, 1, 1, 5, 0);
    run_round(3, 1, 1, 5, 0);
    run_round(1, 1, 1, 5, 0);
    chk("floor_load", int'(load_value), 8);
    chk("four_hits", int'(score), 4);

    // Timeout, wrong position, timeout -> game over with score held
    run_round(1, 1, 0, 0, 0);
    run_round(0, 0, 1, 2, 0);
    run_round(2, 1, 0, 0, 0);
    chk("over_score", int'(score), 4);
    mole_valid = 1'b1;
    tick();
    mole_valid = 1'b0;
    repeat (3) tick();
    chk("over_ignores_mole", int'(game_over), 1);

    // Restart, press while armed, long hold
    do_start();
    whack_n = 1'b0;
    repeat (6) tick();
    chk("arm_press_quiet", int'(hit_pulse | miss_pulse), 0);
    chk("arm_press_timer", int'(timer), 0);
    chk("arm_press_active", int'(active), 1);
    whack_n = 1'b1;
    repeat (4) tick();
    run_round(3, 1, 1, 2, 40);
    run_round(1, 0, 1, 3, 40);

    // Randomised rounds
    for (int r = 0; r < 60; r++) begin
      if (m_over) do_start();
      run_round(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 3) != 0), int'($urandom_range(1, m_load + 2)), 0);
    end

    // Start while a window is open restarts immediately
    if (m_over) do_start();
    mole_valid = 1'b1;
    tick();
    mole_valid = 1'b0;
    repeat (3) tick();
    do_start();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
